integ: RTL and testbench
========================

INTEG -- requirements
Module: integ

Interface
REQ-001 Parameter SAMPLE_W, default 8, width of reconstructed ECG sample.
REQ-002 Parameter DIFF_W, default SAMPLE_W+1 (9), width of offset-binary difference input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear: accumulator to zero, pipeline flushed.
REQ-006 seed_valid  input  1  load seed_data as accumulator base (IDLE only).
REQ-007 seed_data  input  SAMPLE_W  unsigned seed sample.
REQ-008 in_valid  input  1  d_in carries a difference word.
REQ-009 in_ready  output  1  block accepts d_in this cycle.
REQ-010 d_in  input  DIFF_W  offset-binary difference: value = d_in - 256.
REQ-011 out_valid  output  1  d_out holds a reconstructed sample.
REQ-012 out_ready  input  1  downstream accepts d_out this cycle.
REQ-013 d_out  output  SAMPLE_W  reconstructed unsigned sample.
REQ-014 sat  output  1  sticky flag: at least one result clamped since last clr/reset.

Function
REQ-015 Block SHALL be the inverse of the offset-binary differentiator: acc_next = acc + d_in - 256.
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !clr.
REQ-018 Latency SHALL be 1 cycle: sample accepted in cycle N appears on d_out with out_valid in cycle N+1.
REQ-019 Back-to-back transfers SHALL sustain one sample per cycle while out_ready is high.
REQ-020 d_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 Sum SHALL be computed in DIFF_W+1 signed bits (10); no intermediate truncation.
REQ-022 Sum < 0 SHALL clamp to 0; sum > 255 SHALL clamp to 255; either sets sat, and acc takes the clamped value.
REQ-023 FSM states: IDLE, RUN.
REQ-024 IDLE: acc = 0; seed_valid SHALL load acc <= seed_data, no output, stay IDLE.
REQ-025 IDLE: accepted input SHALL produce output and move to RUN.
REQ-026 RUN: seed_valid SHALL be ignored.
REQ-027 clr SHALL, in any state, set acc 0, out_valid 0, sat 0, state IDLE; an in-flight output is discarded.
REQ-028 clr SHALL take priority over seed_valid and over an input transfer in the same cycle.
REQ-029 seed_valid and an input transfer in the same IDLE cycle: seed applied first, difference added to the seed, one output produced.
REQ-030 d_in = 256 SHALL repeat the previous sample unchanged.

Reset
REQ-031 On rst low, asynchronously: state IDLE, acc 0, d_out 0, out_valid 0, sat 0.
REQ-032 in_ready SHALL be 1 during and after reset (out_valid = 0, clr low).
REQ-033 Reset deasserted mid-stream SHALL lose all prior samples; first post-reset output is 0 + (d_in - 256), clamped.

Structure
REQ-034 Shared package ecg_filt_pkg SHALL hold SAMPLE_W, DIFF_W, OFFSET = 256 and the IDLE/RUN state enum, shared with the differentiator.
REQ-035 One combinational sub-module sat_add (signed add, clamp to 0..255, overflow flag) SHALL be used; all registers live in integ.

Verification
REQ-036 Reset, then d_in 356, 356, 156, 256 with out_ready=1 -> d_out 100, 200, 100, 100, one per cycle, sat=0.
REQ-037 Seed 50 in IDLE, then d_in 266 -> d_out 60; further seed_valid in RUN ignored.
REQ-038 From acc 250, d_in 300 -> d_out 255, sat=1; then d_in 0 -> d_out 0; sat stays 1 until clr.
REQ-039 out_ready low 3 cycles with in_valid high -> in_ready 0, d_out held, no sample lost or duplicated; ready restored -> stream resumes in order.
REQ-040 clr with out_valid=1 -> next cycle out_valid 0, sat 0, state IDLE; next d_in 300 -> d_out 44.
REQ-041 Golden model: random 8-bit sequence through the differentiator then integ -> integ output equals the original sequence exactly, sat=0.

Source files
------------

// File: rtl/ecg_filt_pkg.sv
// Shared ECG filter definitions: sample/difference widths, the offset-binary
// bias and the IDLE/RUN state encoding used by the differentiator and integ.
package ecg_filt_pkg;

    localparam int SAMPLE_W = 8;
    localparam int DIFF_W   = SAMPLE_W + 1;
    localparam int OFFSET   = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/integ_if.sv
// Stream/control bundle for the integrator: seed and clear controls, input
// difference handshake, output sample handshake and the saturation flag.
interface integ_if #(
    parameter int SAMPLE_W = 8,
    parameter int DIFF_W   = SAMPLE_W + 1
);
    logic                clr;
    logic                seed_valid;
    logic [SAMPLE_W-1:0] seed_data;
    logic                in_valid;
    logic                in_ready;
    logic [DIFF_W-1:0]   d_in;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] d_out;
    logic                sat;

    modport master (
        output clr, seed_valid, seed_data, in_valid, d_in, out_ready,
        input  in_ready, out_valid, d_out, sat
    );

    modport slave (
        input  clr, seed_valid, seed_data, in_valid, d_in, out_ready,
        output in_ready, out_valid, d_out, sat
    );
endinterface

// File: rtl/integ_sat_add.sv
// Combinational accumulate step: base + (diff - OFFSET) in DIFF_W+1 signed
// bits, clamped to the unsigned sample range, with a flag when clamping.
module sat_add import ecg_filt_pkg::*; #(
    parameter int SAMPLE_W = ecg_filt_pkg::SAMPLE_W,
    parameter int DIFF_W   = SAMPLE_W + 1
) (
    input  logic [SAMPLE_W-1:0] base,
    input  logic [DIFF_W-1:0]   diff,
    output logic [SAMPLE_W-1:0] sum,
    output logic                ovf
);
    localparam logic signed [DIFF_W:0] OFF_S = (DIFF_W+1)'(OFFSET);
    localparam logic signed [DIFF_W:0] MAX_S = (DIFF_W+1)'((1 << SAMPLE_W) - 1);

    logic signed [DIFF_W:0] full;

    // Full-width sum first, so no wrap can hide an out-of-range result.
    assign full = $signed({{(DIFF_W+1-SAMPLE_W){1'b0}}, base})
                + $signed({1'b0, diff})
                - OFF_S;

    // Clamp low on negative, high above the largest sample.
    always_comb begin
        sum = full[SAMPLE_W-1:0];
        ovf = 1'b0;
        if (full < 0) begin
            sum = '0;
            ovf = 1'b1;
        end else if (full > MAX_S) begin
            sum = '1;
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/integ.sv
// Offset-binary integrator: rebuilds ECG samples from difference words with a
// one-deep output register, seed loading in IDLE and a sticky clamp flag.
module integ import ecg_filt_pkg::*; #(
    parameter int SAMPLE_W = ecg_filt_pkg::SAMPLE_W,
    parameter int DIFF_W   = SAMPLE_W + 1
) (
    input  logic  clk,
    input  logic  rst,
    integ_if.slave bus
);
    state_t              state, state_nx;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W-1:0] dout_q;
    logic                ovld_q;
    logic                sat_q;
    logic [SAMPLE_W-1:0] base;
    logic [SAMPLE_W-1:0] sum;
    logic                ovf;
    logic                in_fire;
    logic                seed_ld;

    // Accept whenever the output slot is empty or draining; clr blocks intake.
    assign bus.in_ready  = (!ovld_q || bus.out_ready) && !bus.clr;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign seed_ld       = (state == IDLE) && bus.seed_valid;

    // A same-cycle seed is applied before the difference is added.
    assign base          = seed_ld ? bus.seed_data : acc;

    assign bus.out_valid = ovld_q;
    assign bus.d_out     = dout_q;
    assign bus.sat       = sat_q;

    sat_add #(
        .SAMPLE_W (SAMPLE_W),
        .DIFF_W   (DIFF_W)
    ) u_sat_add (
        .base (base),
        .diff (bus.d_in),
        .sum  (sum),
        .ovf  (ovf)
    );

    // Next state: clr forces IDLE, the first accepted difference enters RUN.
    always_comb begin
        state_nx = state;
        if (bus.clr)
            state_nx = IDLE;
        else if (in_fire)
            state_nx = RUN;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Accumulator, output register and sticky saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            dout_q <= '0;
            ovld_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (bus.clr) begin
            acc    <= '0;
            dout_q <= '0;
            ovld_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (in_fire) begin
            acc    <= sum;
            dout_q <= sum;
            ovld_q <= 1'b1;
            sat_q  <= sat_q | ovf;
        end else begin
            if (bus.out_ready)
                ovld_q <= 1'b0;
            if (seed_ld)
                acc <= bus.seed_data;
        end
    end
endmodule

// File: tb/tb_integ.sv
// Directed bench for integ: reset, streaming, seeding, clamping, stalls,
// clear priority, mid-stream reset and a differentiator round trip.
module tb_integ;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   prev;
    int   xs [20];

    integ_if #(.SAMPLE_W(8), .DIFF_W(9)) bus ();

    integ #(.SAMPLE_W(8), .DIFF_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid   = 1'b0;
        bus.seed_valid = 1'b0;
        bus.clr        = 1'b0;
    endtask

    // One accepted difference with out_ready high; checks the resulting sample.
    task automatic send(input string tag, input int d, input int exp);
        bus.in_valid = 1'b1;
        bus.d_in     = 9'(d);
        #1;
        chk({tag, "_rdy"}, int'(bus.in_ready), 1);
        cyc();
        chk(tag, int'(bus.d_out), exp);
        chk({tag, "_vld"}, int'(bus.out_valid), 1);
    endtask

    task automatic do_clr();
        idle_in();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        idle_in();
        bus.seed_data = '0;
        bus.d_in      = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_vld",  int'(bus.out_valid), 0);
        chk("rst_dout", int'(bus.d_out), 0);
        chk("rst_sat",  int'(bus.sat), 0);
        chk("rst_rdy",  int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("post_rst_rdy", int'(bus.in_ready), 1);

        // Basic back-to-back stream.
        send("s0", 356, 100);
        send("s1", 356, 200);
        send("s2", 156, 100);
        send("s3", 256, 100);
        idle_in();
        cyc();
        chk("s_drain", int'(bus.out_valid), 0);
        chk("s_sat", int'(bus.sat), 0);

        // clr discards a stalled output and wins over a same-cycle input.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.d_in      = 9'd300;
        cyc();
        chk("c_pend", int'(bus.d_out), 144);
        bus.clr = 1'b1;
        #1;
        chk("c_rdy0", int'(bus.in_ready), 0);
        cyc();
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("c_vld", int'(bus.out_valid), 0);
        chk("c_sat", int'(bus.sat), 0);
        bus.out_ready = 1'b1;
        send("c_next", 300, 44);

        // Seed while running is ignored.
        idle_in();
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd50;
        cyc();
        bus.seed_valid = 1'b0;
        send("run_seed", 266, 54);

        // Seed in IDLE.
        do_clr();
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd50;
        cyc();
        bus.seed_valid = 1'b0;
        chk("seed_novld", int'(bus.out_valid), 0);
        send("seed_add", 266, 60);
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd200;
        send("seed_ign", 256, 60);
        bus.seed_valid = 1'b0;

        // High and low clamping with a sticky flag.
        do_clr();
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd250;
        cyc();
        bus.seed_valid = 1'b0;
        send("hi_clamp", 300, 255);
        chk("hi_sat", int'(bus.sat), 1);
        send("lo_clamp", 0, 0);
        send("sticky", 266, 10);
        chk("sticky_sat", int'(bus.sat), 1);
        do_clr();
        chk("clr_sat", int'(bus.sat), 0);

        // Seed and difference in the same IDLE cycle.
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd30;
        send("seed_same", 276, 50);
        bus.seed_valid = 1'b0;

        // clr beats seed and input together.
        bus.clr        = 1'b1;
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'd99;
        bus.in_valid   = 1'b1;
        bus.d_in       = 9'd300;
        cyc();
        idle_in();
        chk("prio_vld", int'(bus.out_valid), 0);
        send("prio_next", 266, 10);
        idle_in();
        cyc();

        // Three-cycle downstream stall.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.d_in      = 9'd266;
        cyc();
        chk("st_first", int'(bus.d_out), 20);
        bus.d_in = 9'd276;
        for (int i = 0; i < 3; i++) begin
            chk("st_rdy0", int'(bus.in_ready), 0);
            cyc();
            chk("st_hold", int'(bus.d_out), 20);
            chk("st_hvld", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        send("st_res0", 276, 40);
        send("st_res1", 246, 30);
        idle_in();
        cyc();
        chk("st_drain", int'(bus.out_valid), 0);

        // Asynchronous reset mid-stream loses history.
        bus.in_valid = 1'b1;
        bus.d_in     = 9'd300;
        cyc();
        chk("mr_pre", int'(bus.d_out), 74);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_vld", int'(bus.out_valid), 0);
        chk("mr_dout", int'(bus.d_out), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        send("mr_first", 100, 0);
        chk("mr_sat", int'(bus.sat), 1);

        // Differentiator round trip with random samples.
        do_clr();
        prev = 0;
        foreach (xs[i]) xs[i] = int'($urandom_range(255, 0));
        foreach (xs[i]) begin
            send("gold", xs[i] + 256 - prev, xs[i]);
            prev = xs[i];
        end
        idle_in();
        cyc();
        chk("gold_sat", int'(bus.sat), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end
endmodule
